pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the fetch stage. It holds the architectural fetch address and advances it by a fixed step on each accepted fetch. It takes redirects from trap, branch, jump and return sources in fixed priority, and presents a valid/ready handshake to instruction memory. An optional return-address stack (RAS) predicts return targets for call/ret pairs.

## Interface
- XLEN, 32, address width
- RESET_VALUE, 32'h0000_0000, PC after reset
- STEP, 4, sequential increment in bytes
- ALIGN_BITS, 2, low target bits forced to 0
- RAS_DEPTH, 4, RAS entries (power of 2, ≥2)
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  freeze sequential advance
- halt  in  1  enter HALT state
- trap  in  1  trap redirect pulse
- trap_vec  in  XLEN  trap target
- br_taken  in  1  branch redirect pulse
- br_target  in  XLEN  branch target
- jmp  in  1  jump redirect pulse
- jmp_target  in  XLEN  jump target
- call  in  1  push link_addr onto RAS
- link_addr  in  XLEN  return address to push
- ret  in  1  pop RAS and redirect to the popped value
- fetch_ready  in  1  memory accepts pc_Out
- fetch_valid  out  1  pc_Out is a valid fetch request
- pc_Out  out  XLEN  registered fetch PC
- ras_empty  out  1  RAS count == 0
- ras_underflow  out  1  registered one-cycle pulse: ret while empty

## Operation
- FSM states: BOOT, RUN, BUBBLE, HALT. Reset puts the FSM in BOOT.
- BOOT → RUN after one cycle. fetch_valid=0 in BOOT.
- RUN, fetch_valid=1:
  - A redirect, if present, loads its target and moves to BUBBLE.
  - With no redirect, fetch_valid & fetch_ready & !stall advances pc_Out by STEP.
  - Otherwise pc_Out holds.
- BUBBLE: fetch_valid=0 for one cycle, then RUN. A redirect in BUBBLE reloads pc_Out and stays in BUBBLE for one more cycle.
- HALT: entered from RUN or BUBBLE when halt=1 and no redirect is present. fetch_valid=0 and pc_Out holds. Only trap exits HALT, going to BUBBLE with pc_Out=trap_vec.
- Redirect priority: trap > br_taken > jmp > ret (valid ret only).
  - Redirects are always accepted, regardless of stall or fetch_ready.
  - In HALT only trap is honoured. br_taken, jmp and ret are ignored, including RAS effects.
- Every loaded target has bits [ALIGN_BITS-1:0] cleared.
- Address arithmetic is modulo 2^XLEN. pc_Out = 2^XLEN − STEP advances to 0.
- RAS:
  - It is a circular buffer with a top pointer and a saturating count.
  - Push when full overwrites the oldest entry, and count stays at RAS_DEPTH.
  - Pop when empty: no redirect, ras_underflow=1 on the next cycle, RAS unchanged. A lower-priority source (none exists below ret) is not affected.
  - call and ret in the same cycle: the popped value is the target, link_addr is written into the same slot, count is unchanged.
  - A ret superseded by a higher-priority redirect still pops. A call is pushed regardless of redirect, except in HALT.

## Timing
- Reset values:
  - pc_Out=RESET_VALUE
  - fetch_valid=0
  - ras_empty=1
  - ras_underflow=0
  - RAS count=0
  - FSM=BOOT
- First fetch_valid=1 appears in the second cycle after rst_n deasserts (one cycle in BOOT).
- Redirect latency: target appears on pc_Out one cycle after the request edge. fetch_valid is 0 in that cycle and returns to 1 one cycle later.
- Sequential advance latency: one cycle.
- rst_n asserted mid-operation forces reset values immediately (asynchronously), including clearing the RAS count.
- fetch_valid and pc_Out are driven from registers only. There is no combinational path from inputs.

## Configuration
- PC_RAS_EN defined: RAS, call, ret, ras_empty and ras_underflow are functional as described.
- PC_RAS_EN undefined:
  - No RAS storage.
  - call and ret are ignored.
  - ras_empty is tied to 1 and ras_underflow is tied to 0.
  - All other behaviour is identical.

## Structure
- Package pc_pkg holds:
  - the FSM state enum (BOOT, RUN, BUBBLE, HALT)
  - the redirect-source enum used for the priority mux
  - the default RESET_VALUE and STEP constants
- One sub-module, pc_ras: circular stack with push, pop, simultaneous replace, count and empty. It is instantiated only under PC_RAS_EN.

## Test plan
- Reset and advance: release rst_n with fetch_ready=1, no redirects → fetch_valid=0 for one cycle, then pc_Out 0x0, 0x4, 0x8 on consecutive cycles.
- Backpressure: fetch_ready=0 for 3 cycles at pc_Out=0x10 → pc_Out holds 0x10. Release → 0x14 next cycle.
- Priority and bubble: trap_vec=0x100, br_target=0x200 and jmp_target=0x300 asserted in the same cycle → pc_Out=0x100, fetch_valid=0 one cycle. A target of 0x203 on its own produces 0x200.
- HALT: halt asserted → fetch_valid=0. br_taken while halted → ignored. trap with trap_vec=0x80 → pc_Out=0x80, then RUN.
- RAS (PC_RAS_EN), depth 4:
  - Push 0x10, 0x20, 0x30, 0x40, 0x50 → ret sequence redirects to 0x50, 0x40, 0x30, 0x20.
  - A fifth ret → no redirect, ras_underflow pulse.
  - Simultaneous call 0x60 and ret → redirect to the top value, top replaced by 0x60.
- Async reset mid-run: rst_n low with pc_Out=0x44 and RAS non-empty → pc_Out=0x0 and ras_empty=1 without waiting for a clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
// Optional return-address stack is enabled with the PC_RAS_EN macro.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      BUBBLE = 2'd2,
      HALT   = 2'd3
   } pc_state_e;

   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_TRAP = 3'd1,
      SRC_BR   = 3'd2,
      SRC_JMP  = 3'd3,
      SRC_RET  = 3'd4
   } redir_src_e;

   localparam logic [31:0] PC_RESET_VALUE = 32'h0000_0000;
   localparam int unsigned PC_STEP        = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, same-slot replace, saturating count.
// Instantiated by pc_unit only when PC_RAS_EN is defined.
module pc_ras
   import pc_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [XLEN-1:0] data_i,
   output logic [XLEN-1:0] top_o,
   output logic            empty_o
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [PW-1:0]   top_q, top_d;
   logic [PW:0]     cnt_q, cnt_d;
   logic [XLEN-1:0] mem_q [DEPTH];
   logic            wr_en;
   logic [PW-1:0]   wr_idx;

   always_comb begin
      top_d  = top_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_idx = top_q;
      if (push_i && pop_i && (cnt_q != '0)) begin
         // pop returns the current top, then the link overwrites that same slot
         wr_en = 1'b1;
      end else if (push_i) begin
         top_d  = top_q + 1'b1;
         wr_idx = top_q + 1'b1;
         wr_en  = 1'b1;
         cnt_d  = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
      end else if (pop_i && (cnt_q != '0)) begin
         top_d = top_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= data_i;
   end

   assign top_o   = mem_q[top_q];
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects and valid/ready fetch handshake.
// Define PC_RAS_EN to build in the return-address stack (call/ret prediction).
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VALUE = XLEN'(PC_RESET_VALUE),
   parameter int unsigned     STEP        = PC_STEP,
   parameter int unsigned     ALIGN_BITS  = 2,
   parameter int unsigned     RAS_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            halt,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jmp,
   input  logic [XLEN-1:0] jmp_target,
   input  logic            call,
   input  logic [XLEN-1:0] link_addr,
   input  logic            ret,
   input  logic            fetch_ready,
   output logic            fetch_valid,
   output logic [XLEN-1:0] pc_Out,
   output logic            ras_empty,
   output logic            ras_underflow
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   redir_src_e      src;
   logic [XLEN-1:0] tgt;
   logic            ret_ok;
   logic [XLEN-1:0] ras_top;

`ifdef PC_RAS_EN
   logic ras_act;
   logic ras_empty_w;
   logic uf_q, uf_d;

   // HALT freezes the stack entirely; a ret superseded by a higher redirect still pops
   assign ras_act = (state_q != HALT);
   assign ret_ok  = ret && !ras_empty_w;
   assign uf_d    = ret && ras_act && ras_empty_w;

   pc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (call && ras_act),
      .pop_i   (ret_ok && ras_act),
      .data_i  (link_addr),
      .top_o   (ras_top),
      .empty_o (ras_empty_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) uf_q <= 1'b0;
      else        uf_q <= uf_d;
   end

   assign ras_empty     = ras_empty_w;
   assign ras_underflow = uf_q;
`else
   logic unused_ok;

   assign unused_ok     = ^{call, ret, link_addr, 1'(RAS_DEPTH)};
   assign ret_ok        = 1'b0;
   assign ras_top       = '0;
   assign ras_empty     = 1'b1;
   assign ras_underflow = 1'b0;
`endif

   always_comb begin
      src = SRC_NONE;
      tgt = '0;
      if (trap) begin
         src = SRC_TRAP;
         tgt = trap_vec;
      end else if (state_q != HALT) begin
         if (br_taken) begin
            src = SRC_BR;
            tgt = br_target;
         end else if (jmp) begin
            src = SRC_JMP;
            tgt = jmp_target;
         end else if (ret_ok) begin
            src = SRC_RET;
            tgt = ras_top;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (src != SRC_NONE) begin
         pc_d    = tgt & ALIGN_MASK;
         state_d = BUBBLE;
      end else begin
         unique case (state_q)
            BOOT:   state_d = RUN;
            RUN: begin
               if (halt) state_d = HALT;
               else if (valid_q && fetch_ready && !stall) pc_d = pc_q + XLEN'(STEP);
            end
            BUBBLE: state_d = halt ? HALT : RUN;
            HALT:   state_d = HALT;
            default: state_d = BOOT;
         endcase
      end
      valid_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VALUE;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign fetch_valid = valid_q;
   assign pc_Out      = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit; expectations cover both PC_RAS_EN builds.
module tb_pc_unit;

   localparam int unsigned XLEN = 32;
`ifdef PC_RAS_EN
   localparam bit HAS_RAS = 1'b1;
`else
   localparam bit HAS_RAS = 1'b0;
`endif
   localparam logic E_PUSHED = HAS_RAS ? 1'b0 : 1'b1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            stall, halt, trap, br_taken, jmp, call, ret, fetch_ready;
   logic [XLEN-1:0] trap_vec, br_target, jmp_target, link_addr;
   logic            fetch_valid, ras_empty, ras_underflow;
   logic [XLEN-1:0] pc_Out;

   typedef struct {
      string           tag;
      logic            v;
      logic [XLEN-1:0] pc;
      logic            e;
      logic            u;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pc_unit #(
      .XLEN        (XLEN),
      .RESET_VALUE (32'h0000_0000),
      .STEP        (4),
      .ALIGN_BITS  (2),
      .RAS_DEPTH   (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .halt          (halt),
      .trap          (trap),
      .trap_vec      (trap_vec),
      .br_taken      (br_taken),
      .br_target     (br_target),
      .jmp           (jmp),
      .jmp_target    (jmp_target),
      .call          (call),
      .link_addr     (link_addr),
      .ret           (ret),
      .fetch_ready   (fetch_ready),
      .fetch_valid   (fetch_valid),
      .pc_Out        (pc_Out),
      .ras_empty     (ras_empty),
      .ras_underflow (ras_underflow)
   );

   task automatic push_exp(input string tag, input logic v, input logic [XLEN-1:0] pc,
                           input logic e, input logic u);
      exp_t x;
      x.tag = tag; x.v = v; x.pc = pc; x.e = e; x.u = u;
      q.push_back(x);
   endtask

   task automatic check_front();
      exp_t x;
      logic [XLEN+2:0] obs, ex;
      vectors++;
      if (q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard: observed empty queue, expected an entry");
      end else begin
         x   = q.pop_front();
         obs = {fetch_valid, pc_Out, ras_empty, ras_underflow};
         ex  = {x.v, x.pc, x.e, x.u};
         assert (obs === ex) else begin
            miscompares++;
            $error("FAIL %s: observed v=%b pc=%h e=%b u=%b, expected v=%b pc=%h e=%b u=%b",
                   x.tag, fetch_valid, pc_Out, ras_empty, ras_underflow, x.v, x.pc, x.e, x.u);
         end
      end
   endtask

   task automatic step(input string tag, input logic v, input logic [XLEN-1:0] pc,
                       input logic e, input logic u);
      push_exp(tag, v, pc, e, u);
      @(posedge clk);
      #1;
      check_front();
   endtask

   task automatic now(input string tag, input logic v, input logic [XLEN-1:0] pc,
                      input logic e, input logic u);
      push_exp(tag, v, pc, e, u);
      check_front();
   endtask

   task automatic idle();
      trap = 1'b0; br_taken = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
      halt = 1'b0; stall = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; fetch_ready = 1'b1;
      trap_vec = '0; br_target = '0; jmp_target = '0; link_addr = '0;
      idle();
      @(posedge clk); #1;
      now("reset", 1'b0, 32'h0, 1'b1, 1'b0);
      rst_n = 1'b1;
      step("boot",  1'b1, 32'h0,  1'b1, 1'b0);
      step("adv4",  1'b1, 32'h4,  1'b1, 1'b0);
      step("adv8",  1'b1, 32'h8,  1'b1, 1'b0);
      step("advc",  1'b1, 32'hc,  1'b1, 1'b0);
      step("adv10", 1'b1, 32'h10, 1'b1, 1'b0);

      fetch_ready = 1'b0;
      step("bp1", 1'b1, 32'h10, 1'b1, 1'b0);
      step("bp2", 1'b1, 32'h10, 1'b1, 1'b0);
      step("bp3", 1'b1, 32'h10, 1'b1, 1'b0);
      fetch_ready = 1'b1;
      step("bp_rel", 1'b1, 32'h14, 1'b1, 1'b0);

      trap = 1'b1; trap_vec = 32'h100; br_taken = 1'b1; br_target = 32'h200;
      jmp = 1'b1; jmp_target = 32'h300;
      step("prio_trap", 1'b0, 32'h100, 1'b1, 1'b0);
      idle();
      step("prio_bub", 1'b1, 32'h100, 1'b1, 1'b0);
      step("prio_adv", 1'b1, 32'h104, 1'b1, 1'b0);
      br_taken = 1'b1; br_target = 32'h203;
      step("align", 1'b0, 32'h200, 1'b1, 1'b0);
      idle();
      step("align_run", 1'b1, 32'h200, 1'b1, 1'b0);
      stall = 1'b1;
      step("stall_hold", 1'b1, 32'h200, 1'b1, 1'b0);
      jmp = 1'b1; jmp_target = 32'h300;
      step("stall_jmp", 1'b0, 32'h300, 1'b1, 1'b0);
      idle();
      step("jmp_run", 1'b1, 32'h300, 1'b1, 1'b0);
      step("jmp_adv", 1'b1, 32'h304, 1'b1, 1'b0);
      jmp = 1'b1; jmp_target = 32'h400;
      step("jmp400", 1'b0, 32'h400, 1'b1, 1'b0);
      jmp_target = 32'h500;
      step("bub_redir", 1'b0, 32'h500, 1'b1, 1'b0);
      idle();
      step("bub_run", 1'b1, 32'h500, 1'b1, 1'b0);

      halt = 1'b1;
      step("halt", 1'b0, 32'h500, 1'b1, 1'b0);
      br_taken = 1'b1; br_target = 32'h600;
      step("halt_br", 1'b0, 32'h500, 1'b1, 1'b0);
      idle();
      step("halt_stay", 1'b0, 32'h500, 1'b1, 1'b0);
      trap = 1'b1; trap_vec = 32'h80;
      step("halt_trap", 1'b0, 32'h80, 1'b1, 1'b0);
      idle();
      step("halt_run", 1'b1, 32'h80, 1'b1, 1'b0);
      step("halt_adv", 1'b1, 32'h84, 1'b1, 1'b0);

      jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
      step("wrap_jmp", 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0);
      idle();
      step("wrap_run", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
      step("wrap_0",   1'b1, 32'h0,         1'b1, 1'b0);

`ifdef PC_RAS_EN
      call = 1'b1;
      link_addr = 32'h10; step("push10", 1'b1, 32'h4,  1'b0, 1'b0);
      link_addr = 32'h20; step("push20", 1'b1, 32'h8,  1'b0, 1'b0);
      link_addr = 32'h30; step("push30", 1'b1, 32'hc,  1'b0, 1'b0);
      link_addr = 32'h40; step("push40", 1'b1, 32'h10, 1'b0, 1'b0);
      link_addr = 32'h50; step("push50", 1'b1, 32'h14, 1'b0, 1'b0);
      call = 1'b0; ret = 1'b1;
      step("ret50", 1'b0, 32'h50, 1'b0, 1'b0);
      step("ret40", 1'b0, 32'h40, 1'b0, 1'b0);
      step("ret30", 1'b0, 32'h30, 1'b0, 1'b0);
      step("ret20", 1'b0, 32'h20, 1'b1, 1'b0);
      step("ret_uf", 1'b1, 32'h20, 1'b1, 1'b1);
      ret = 1'b0;
      step("uf_clear", 1'b1, 32'h24, 1'b1, 1'b0);
      call = 1'b1; link_addr = 32'h70;
      step("push70", 1'b1, 32'h28, 1'b0, 1'b0);
      link_addr = 32'h60; ret = 1'b1;
      step("callret", 1'b0, 32'h70, 1'b0, 1'b0);
      idle();
      step("callret_run", 1'b1, 32'h70, 1'b0, 1'b0);
      ret = 1'b1;
      step("ret60", 1'b0, 32'h60, 1'b1, 1'b0);
      idle();
      step("ret60_run", 1'b1, 32'h60, 1'b1, 1'b0);
      call = 1'b1; link_addr = 32'h90;
      step("push90", 1'b1, 32'h64, 1'b0, 1'b0);
      call = 1'b0; ret = 1'b1; jmp = 1'b1; jmp_target = 32'h900;
      step("ret_superseded", 1'b0, 32'h900, 1'b1, 1'b0);
      idle();
      step("sup_run", 1'b1, 32'h900, 1'b1, 1'b0);
`else
      call = 1'b1; link_addr = 32'h10;
      step("call_ign", 1'b1, 32'h4, 1'b1, 1'b0);
      call = 1'b0; ret = 1'b1;
      step("ret_ign", 1'b1, 32'h8, 1'b1, 1'b0);
      idle();
`endif

      jmp = 1'b1; jmp_target = 32'h44;
      step("jmp44", 1'b0, 32'h44, 1'b1, 1'b0);
      idle();
      fetch_ready = 1'b0; call = 1'b1; link_addr = 32'hAA;
      step("hold44", 1'b1, 32'h44, E_PUSHED, 1'b0);
      call = 1'b0;
      #3 rst_n = 1'b0;
      #1 now("async_rst", 1'b0, 32'h0, 1'b1, 1'b0);
      #1 rst_n = 1'b1;
      fetch_ready = 1'b1;
      step("boot2", 1'b1, 32'h0, 1'b1, 1'b0);
      ret = 1'b1;
      step("ret_after_rst", 1'b1, 32'h4, 1'b1, HAS_RAS);
      idle();
      step("post_rst_adv", 1'b1, 32'h8, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
